// File: rtl/bram_readout_streamer.sv
// bram_readout_streamer: sweeps the capture BRAM from address 0 and streams the words over valid/ready.
module bram_readout_streamer #(
  parameter int DEPTH = 16384,
  parameter int AW = 31
) (
  input  logic          axi_clk,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [AW:0]   len_i,
  input  logic          abort_i,
  input  logic          cap_ready_i,
  output logic [AW-1:0] bram_addr_o,
  input  logic [63:0]   bram_rdata_i,
  output logic [63:0]   m_data_o,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic          m_last_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          aborted_o
);
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_STREAM} state_t;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
  state_t state;
  logic [1:0] rdy_q, cnt, credit;
  logic [AW:0] len, issued, accepted;
  logic [63:0] mem [2];
  logic wp, rp, inflight, pop, last_pop, issue, abort_hit;
  always_ff @(posedge axi_clk or negedge rst_ni)
    if (!rst_ni) rdy_q <= '0;
    else rdy_q <= {rdy_q[0], cap_ready_i};
  assign m_valid_o = cnt != 2'd0;
  assign m_data_o = mem[rp];
  assign m_last_o = m_valid_o && (accepted == len - ONE);
  assign busy_o = state != ST_IDLE;
  assign pop = m_valid_o && m_ready_i;
  assign last_pop = pop && (accepted + ONE == len);
  // slot freed by this cycle's pop counts as credit, so ready-high streaming sustains 1 word/cycle
  assign credit = cnt + {1'b0, inflight} - {1'b0, pop};
  assign issue = state == ST_STREAM && !abort_i && issued < len && credit < 2'd2;
  assign abort_hit = abort_i && state != ST_IDLE && !last_pop;
  always_ff @(posedge axi_clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
      len <= '0;
      issued <= '0;
      accepted <= '0;
      bram_addr_o <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= '0;
      inflight <= 1'b0;
      done_o <= 1'b0;
      aborted_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      inflight <= issue;
      cnt <= cnt + {1'b0, inflight} - {1'b0, pop};
      if (inflight) begin
        mem[wp] <= bram_rdata_i;
        wp <= ~wp;
      end
      if (pop) begin
        rp <= ~rp;
        accepted <= accepted + ONE;
      end
      if (issue) begin
        issued <= issued + ONE;
        if (issued + ONE < len) bram_addr_o <= bram_addr_o + 1'b1;
      end
      case (state)
        ST_IDLE: if (start_i) begin
          len <= len_i > DEPTH_L ? DEPTH_L : len_i;
          aborted_o <= 1'b0;
          if (len_i == '0) done_o <= 1'b1;
          else state <= ST_WAIT;
        end
        ST_WAIT: if (rdy_q[1]) begin
          state <= ST_STREAM;
          bram_addr_o <= '0;
          issued <= '0;
          accepted <= '0;
        end
        ST_STREAM: if (last_pop) begin
          state <= ST_IDLE;
          bram_addr_o <= '0;
          done_o <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
      if (abort_hit) begin
        state <= ST_IDLE;
        bram_addr_o <= '0;
        cnt <= '0;
        inflight <= 1'b0;
        wp <= 1'b0;
        rp <= 1'b0;
        done_o <= 1'b1;
        aborted_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bram_readout_streamer.sv
// tb_bram_readout_streamer: randomized directed checks of the streamer against a word-sequence model.
module tb_bram_readout_streamer;
  localparam int DEPTH = 16384;
  localparam int AW = 31;
  logic axi_clk = 0, rst_ni = 0, start_i = 0, abort_i = 0, cap_ready_i = 0, m_ready_i = 0;
  logic [AW:0] len_i = '0;
  logic [AW-1:0] bram_addr_o;
  logic [63:0] bram_rdata_i = '0;
  logic [63:0] m_data_o;
  logic m_valid_o, m_last_o, busy_o, done_o, aborted_o;
  int checks = 0, errors = 0, cyc_n = 0, done_cnt = 0, rise_cyc = 0, dsave = 0;
  logic [31:0] seed = 0;
  logic [AW-1:0] max_addr = '0;
  logic [63:0] got_q[$];
  logic last_q[$];
  int beat_cyc[$];
  logic hold_v = 0, hold_l = 0;
  logic [63:0] hold_d = '0;
  int pat[6] = '{1, 0, 0, 1, 0, 1};

  bram_readout_streamer dut (
    .axi_clk(axi_clk), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
    .abort_i(abort_i), .cap_ready_i(cap_ready_i), .bram_addr_o(bram_addr_o),
    .bram_rdata_i(bram_rdata_i), .m_data_o(m_data_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .m_last_o(m_last_o), .busy_o(busy_o),
    .done_o(done_o), .aborted_o(aborted_o)
  );

  function automatic logic [63:0] word(input logic [AW-1:0] a);
    return {seed ^ (32'(a) * 32'h9E3779B9), 1'b0, a};
  endfunction

  always #5 axi_clk = ~axi_clk;
  always @(posedge axi_clk) cyc_n <= cyc_n + 1;
  always @(posedge axi_clk) bram_rdata_i <= word(bram_addr_o);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge axi_clk);
    #1;
  endtask

  always @(negedge axi_clk) begin
    if (hold_v && rst_ni) begin
      chk("stall_valid", m_valid_o, 1);
      chk("stall_data", m_data_o, hold_d);
      chk("stall_last", m_last_o, hold_l);
    end
    if (m_valid_o && m_ready_i) begin
      got_q.push_back(m_data_o);
      last_q.push_back(m_last_o);
      beat_cyc.push_back(cyc_n);
    end
    if (done_o) done_cnt++;
    if (bram_addr_o > max_addr) max_addr = bram_addr_o;
    hold_v = rst_ni && m_valid_o && !m_ready_i && !abort_i;
    hold_d = m_data_o;
    hold_l = m_last_o;
  end

  task automatic run(input int len, input int mode, input int dly, input string tag);
    int n, d0, bad, nlast;
    n = len > DEPTH ? DEPTH : len;
    got_q.delete();
    last_q.delete();
    beat_cyc.delete();
    max_addr = '0;
    seed = $urandom;
    d0 = done_cnt;
    len_i = (AW+1)'(len);
    start_i = 1;
    cyc();
    start_i = 0;
    chk({tag, "_abort_clr"}, aborted_o, 0);
    chk({tag, "_busy"}, busy_o, n > 0);
    chk({tag, "_done_imm"}, done_o, n == 0);
    if (dly > 0) begin
      repeat (dly) cyc();
      chk({tag, "_wait_addr"}, max_addr, 0);
      chk({tag, "_wait_beats"}, got_q.size(), 0);
      chk({tag, "_wait_busy"}, busy_o, 1);
      cap_ready_i = 1;
      rise_cyc = cyc_n;
    end
    for (int i = 0; i < 4 * n + 200 && done_cnt == d0; i++) begin
      m_ready_i = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : 1'(pat[i % 6]);
      cyc();
    end
    chk({tag, "_done_seen"}, done_cnt - d0, 1);
    repeat (2) cyc();
    chk({tag, "_done_once"}, done_cnt - d0, 1);
    chk({tag, "_busy_end"}, busy_o, 0);
    chk({tag, "_done_low"}, done_o, 0);
    bad = 0;
    nlast = 0;
    foreach (got_q[i]) begin
      if (got_q[i] !== word(31'(i))) bad++;
      if (last_q[i]) nlast++;
    end
    chk({tag, "_beats"}, got_q.size(), n);
    chk({tag, "_data_bad"}, bad, 0);
    chk({tag, "_last_cnt"}, nlast, n > 0);
    chk({tag, "_last_pos"}, (got_q.size() == n && n > 0) ? last_q[n-1] : 1'b0, n > 0);
    chk({tag, "_max_addr"}, max_addr, n > 0 ? n - 1 : 0);
  endtask

  initial begin
    repeat (3) cyc();
    chk("rst_valid", m_valid_o, 0);
    chk("rst_last", m_last_o, 0);
    chk("rst_data", m_data_o, 0);
    chk("rst_addr", bram_addr_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_aborted", aborted_o, 0);
    rst_ni = 1;
    cap_ready_i = 1;
    m_ready_i = 1;
    repeat (3) cyc();
    chk("idle_valid", m_valid_o, 0);
    run(4, 0, 0, "len4");
    chk("len4_consec", beat_cyc[3] - beat_cyc[0], 3);
    run(8, 2, 0, "len8_pat");
    for (int k = 0; k < 6; k++) run($urandom_range(1, 40), 1, 0, $sformatf("rand%0d", k));
    cap_ready_i = 0;
    repeat (4) cyc();
    run(4, 0, 20, "late_ready");
    chk("late_latency", beat_cyc[0] - rise_cyc >= 4 && beat_cyc[0] - rise_cyc <= 6, 1);
    run(0, 0, 0, "len0");
    run(DEPTH + 5, 0, 0, "overlen");
    got_q.delete();
    last_q.delete();
    seed = $urandom;
    m_ready_i = 1;
    len_i = 10;
    start_i = 1;
    cyc();
    start_i = 0;
    for (int i = 0; i < 100 && got_q.size() < 3; i++) cyc();
    m_ready_i = 0;
    repeat (3) cyc();
    dsave = done_cnt;
    abort_i = 1;
    cyc();
    abort_i = 0;
    chk("ab_valid", m_valid_o, 0);
    chk("ab_done", done_o, 1);
    chk("ab_aborted", aborted_o, 1);
    chk("ab_busy", busy_o, 0);
    repeat (3) cyc();
    chk("ab_beats", got_q.size(), 3);
    chk("ab_data2", got_q[2], word(31'd2));
    chk("ab_sticky", aborted_o, 1);
    chk("ab_done_once", done_cnt - dsave, 1);
    run(5, 0, 0, "after_abort");
    m_ready_i = 0;
    len_i = 20;
    start_i = 1;
    cyc();
    start_i = 0;
    repeat (8) cyc();
    chk("pre_rst_valid", m_valid_o, 1);
    chk("pre_rst_addr", bram_addr_o, 2);
    #1 rst_ni = 0;
    #1;
    chk("arst_valid", m_valid_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_addr", bram_addr_o, 0);
    chk("arst_last", m_last_o, 0);
    cyc();
    rst_ni = 1;
    repeat (2) cyc();
    run(6, 1, 0, "after_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
